cv32e40x_aes_share_issue: RTL and testbench

CV32E40X_AES_SHARE_ISSUE -- requirements
Module: cv32e40x_aes_share_issue

---
 rtl/cv32e40x_aes_share_issue.sv | 177 +++++++++++++++++
 tb/tb_cv32e40x_aes_share_issue.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40x_aes_share_issue.sv
// Issue stage for a masked saes32 FU: holds the request, splits the selected state byte into two
// DOM shares and returns the FU result after a fixed latency. Define CV32E40X_AES_SHARE_MASK_EN
// to enable the randomness LFSR; otherwise the mask and randomness outputs are tied to zero.
module cv32e40x_aes_share_issue #(
  parameter int unsigned SBOX_LATENCY = 4,
  parameter logic [47:0] LFSR_SEED    = 48'h0000_C0DE_A5E5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_rs1_i,
  input  logic [31:0] req_rs2_i,
  input  logic [1:0]  req_bs_i,
  input  logic [1:0]  req_op_i,
  input  logic        flush_i,
  output logic        fu_valid_o,
  output logic [31:0] fu_rs1_o,
  output logic [31:0] fu_rs2_o,
  output logic [31:0] fu_rs3_o,
  output logic [1:0]  fu_bs_o,
  output logic        fu_op_decs_o,
  output logic        fu_op_decsm_o,
  output logic        fu_op_encs_o,
  output logic        fu_op_encsm_o,
  output logic [35:0] fu_randombits_o,
  input  logic [31:0] fu_rd_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rd_o,
  output logic        busy_o
);

  localparam int unsigned CntW = (SBOX_LATENCY > 0) ? $clog2(SBOX_LATENCY + 1) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(SBOX_LATENCY);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     rs1_q;
  logic [7:0]      xm_q;
  logic [7:0]      mask_q;
  logic [1:0]      bs_q;
  logic [1:0]      op_q;
  logic [31:0]     rsp_rd_q;

  logic            accept;
  logic            rsp_load;
  logic [7:0]      sel_byte;
  logic [7:0]      mask;
  logic [35:0]     rand_bits;

`ifdef CV32E40X_AES_SHARE_MASK_EN
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [47:0] SeedEff = (LFSR_SEED == 48'h0) ? 48'h1 : LFSR_SEED;

  logic [47:0] lfsr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= SeedEff;
    end else begin
      lfsr_q <= {lfsr_q[46:0], lfsr_q[47] ^ lfsr_q[46] ^ lfsr_q[20] ^ lfsr_q[19]};
    end
  end

  assign mask      = lfsr_q[7:0];
  assign rand_bits = lfsr_q[43:8];
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  assign mask        = 8'h00;
  assign rand_bits   = 36'h0;
`endif

  assign req_ready_o = (state_q == StIdle) || ((state_q == StResp) && rsp_ready_i);
  assign accept      = req_valid_i && req_ready_o && !flush_i;
  assign rsp_load    = (state_q == StBusy) && (cnt_q == '0) && !flush_i;
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_rd_o    = rsp_rd_q;
  assign busy_o      = (state_q != StIdle);

  always_comb begin
    sel_byte = 8'h00;
    case (req_bs_i)
      2'd0:    sel_byte = req_rs2_i[7:0];
      2'd1:    sel_byte = req_rs2_i[15:8];
      2'd2:    sel_byte = req_rs2_i[23:16];
      default: sel_byte = req_rs2_i[31:24];
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: ;
      StBusy: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (accept) begin
      state_d = StBusy;
      cnt_d   = CntInit;
    end
    // Flush overrides both the normal sequencing and a simultaneous accept.
    if (flush_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rs1_q    <= '0;
      xm_q     <= '0;
      mask_q   <= '0;
      bs_q     <= '0;
      op_q     <= '0;
      rsp_rd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rs1_q  <= req_rs1_i;
        xm_q   <= sel_byte ^ mask;
        mask_q <= mask;
        bs_q   <= req_bs_i;
        op_q   <= req_op_i;
      end
      if (rsp_load) begin
        rsp_rd_q <= fu_rd_i;
      end
    end
  end

  always_comb begin
    fu_valid_o      = 1'b0;
    fu_rs1_o        = '0;
    fu_rs2_o        = '0;
    fu_rs3_o        = '0;
    fu_bs_o         = '0;
    fu_op_encs_o    = 1'b0;
    fu_op_encsm_o   = 1'b0;
    fu_op_decs_o    = 1'b0;
    fu_op_decsm_o   = 1'b0;
    fu_randombits_o = '0;
    if (state_q == StBusy) begin
      fu_valid_o      = 1'b1;
      fu_rs1_o        = rs1_q;
      fu_rs2_o        = {xm_q, xm_q, 16'h0000};
      fu_rs3_o        = {16'h0000, mask_q, mask_q};
      fu_bs_o         = bs_q;
      fu_randombits_o = rand_bits;
      case (op_q)
        2'b00:   fu_op_encs_o  = 1'b1;
        2'b01:   fu_op_encsm_o = 1'b1;
        2'b10:   fu_op_decs_o  = 1'b1;
        default: fu_op_decsm_o = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_cv32e40x_aes_share_issue.sv
// Bench for cv32e40x_aes_share_issue: a pipelined saes32 FU model, a response scoreboard,
// a vector table and hand-written flush/reset/back-to-back sequences.
`timescale 1ns/1ps
module tb_cv32e40x_aes_share_issue;

  localparam int unsigned Lat = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_rs1_i = '0;
  logic [31:0] req_rs2_i = '0;
  logic [1:0]  req_bs_i = '0;
  logic [1:0]  req_op_i = '0;
  logic        flush_i = 1'b0;
  logic        fu_valid_o;
  logic [31:0] fu_rs1_o, fu_rs2_o, fu_rs3_o;
  logic [1:0]  fu_bs_o;
  logic        fu_op_decs_o, fu_op_decsm_o, fu_op_encs_o, fu_op_encsm_o;
  logic [35:0] fu_randombits_o;
  logic [31:0] fu_rd_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_rd_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cv32e40x_aes_share_issue #(
    .SBOX_LATENCY(Lat)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_rs1_i      (req_rs1_i),
    .req_rs2_i      (req_rs2_i),
    .req_bs_i       (req_bs_i),
    .req_op_i       (req_op_i),
    .flush_i        (flush_i),
    .fu_valid_o     (fu_valid_o),
    .fu_rs1_o       (fu_rs1_o),
    .fu_rs2_o       (fu_rs2_o),
    .fu_rs3_o       (fu_rs3_o),
    .fu_bs_o        (fu_bs_o),
    .fu_op_decs_o   (fu_op_decs_o),
    .fu_op_decsm_o  (fu_op_decsm_o),
    .fu_op_encs_o   (fu_op_encs_o),
    .fu_op_encsm_o  (fu_op_encsm_o),
    .fu_randombits_o(fu_randombits_o),
    .fu_rd_i        (fu_rd_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_rd_o       (rsp_rd_o),
    .busy_o         (busy_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- AES reference arithmetic for the FU model ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h00;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xt(p);
    end
    return r;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] g;
    g = ginv(a);
    return g ^ rotl8(g, 1) ^ rotl8(g, 2) ^ rotl8(g, 3) ^ rotl8(g, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] fu_model(input logic dec, input logic mix, input logic [1:0] bs,
                                           input logic [31:0] rs1, input logic [7:0] x);
    logic [7:0]  s;
    logic [31:0] col;
    logic [63:0] t;
    s = dec ? inv_sbox(x) : sbox(x);
    if (!mix)     col = {24'h0, s};
    else if (dec) col = {gmul(s, 8'h0b), gmul(s, 8'h0d), gmul(s, 8'h09), gmul(s, 8'h0e)};
    else          col = {gmul(s, 8'h03), s, s, gmul(s, 8'h02)};
    t = {col, col} << (8 * int'(bs));
    return rs1 ^ t[63:32];
  endfunction

  // FU model: Lat register stages, recombining the two shares of the state byte.
  logic [31:0] pipe [Lat];
  always @(posedge clk) begin
    pipe[0] <= fu_valid_o ? fu_model(fu_op_decs_o | fu_op_decsm_o, fu_op_encsm_o | fu_op_decsm_o,
                                     fu_bs_o, fu_rs1_o, fu_rs2_o[31:24] ^ fu_rs3_o[7:0]) : 32'h0;
    for (int i = 1; i < Lat; i++) pipe[i] <= pipe[i-1];
  end
  assign fu_rd_i = pipe[Lat-1];

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] rd;
    int          edge_no;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] cur_exp = '0;
  logic        rsp_prev = 1'b0;

  always @(negedge clk) begin
    sb_t e;
    if (reset_n) begin
      if (rsp_valid_o && !rsp_prev) begin
        check("rsp_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          check("rsp_rd", 64'(rsp_rd_o), 64'(sb[0].rd));
          // The accepting edge counts as the first edge.
          check("latency", 64'(cyc - sb[0].edge_no + 1), 64'(Lat + 2));
        end
      end
      if (rsp_valid_o && rsp_ready_i && sb.size() != 0) void'(sb.pop_front());
      if (req_valid_i && req_ready_o && !flush_i) begin
        e.rd      = cur_exp;
        e.edge_no = cyc + 1;
        sb.push_back(e);
      end
      if (!busy_o) begin
        check("fu_idle_zero", 64'(|{fu_valid_o, fu_rs1_o, fu_rs2_o, fu_rs3_o, fu_bs_o,
                                     fu_op_decs_o, fu_op_decsm_o, fu_op_encs_o, fu_op_encsm_o,
                                     fu_randombits_o}), 64'd0);
      end
    end
    rsp_prev = reset_n ? rsp_valid_o : 1'b0;
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [1:0] bs, input logic [31:0] exp);
    bit ok;
    ok          = 1'b0;
    cur_exp     = exp;
    req_op_i    = op;
    req_rs1_i   = rs1;
    req_rs2_i   = rs2;
    req_bs_i    = bs;
    req_valid_i = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = req_ready_o;
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int n = 0; n < 50 && !rsp_valid_o; n++) @(negedge clk);
    check("rsp_timeout", 64'(rsp_valid_o), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic no_rsp_window(input string name);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check(name, 64'(rsp_valid_o), 64'd0);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [1:0]  bs;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] m1, m2;
    vecs[0] = '{2'b00, 32'h0000_0000, 32'h0000_0053, 2'd0, 32'h0000_00ED};
    vecs[1] = '{2'b10, 32'h1111_1111, 32'h0000_ED00, 2'd1, 32'h1111_4211};
    vecs[2] = '{2'b01, 32'h0000_0000, 32'h0000_0001, 2'd0, 32'h847C_7CF8};
    vecs[3] = '{2'b00, 32'h0000_FFFF, 32'h0000_0000, 2'd3, 32'h6300_FFFF};
    vecs[4] = '{2'b01, 32'h0000_0000, 32'h0000_0000, 2'd2, 32'h63C6_A563};
    vecs[5] = '{2'b11, 32'hA5A5_A5A5, 32'h0063_0000, 2'd2, 32'hA5A5_A5A5};
    vecs[6] = '{2'b10, 32'h0000_0000, 32'h0000_0000, 2'd0, 32'h0000_0052};

    // Reset state, sampled while reset is held.
    #12;
    check("rst_req_ready", 64'(req_ready_o), 64'd1);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_rsp_rd", 64'(rsp_rd_o), 64'd0);
    check("rst_fu_valid", 64'(fu_valid_o), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].bs, vecs[i].exp);
      check("busy_after_accept", 64'(busy_o), 64'd1);
      wait_rsp();
    end

    // Held response with stalled consumer, then back-to-back accept on the handshake cycle.
    rsp_ready_i = 1'b0;
    issue(2'b01, 32'h0, 32'h0000_0001, 2'd0, 32'h847C_7CF8);
    for (int n = 0; n < 50 && !rsp_valid_o; n++) @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      check("hold_valid", 64'(rsp_valid_o), 64'd1);
      check("hold_rd", 64'(rsp_rd_o), 64'h847C_7CF8);
      check("hold_req_ready", 64'(req_ready_o), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    cur_exp     = 32'h0000_00ED;
    req_op_i    = 2'b00;
    req_rs1_i   = 32'h0;
    req_rs2_i   = 32'h0000_0053;
    req_bs_i    = 2'd0;
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1;
    @(negedge clk);
    check("b2b_req_ready", 64'(req_ready_o), 64'd1);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    check("b2b_busy", 64'(busy_o), 64'd1);
    check("b2b_rsp_dropped", 64'(rsp_valid_o), 64'd0);
    wait_rsp();

    // Flush on BUSY cycle 2.
    issue(2'b00, 32'h0, 32'h0000_0053, 2'd0, 32'h0000_00ED);
    @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    sb.delete();
    check("flush_idle", 64'(busy_o), 64'd0);
    check("flush_req_ready", 64'(req_ready_o), 64'd1);
    no_rsp_window("flush_no_rsp");

    // Asynchronous reset on BUSY cycle 2.
    issue(2'b01, 32'h0, 32'h0000_0001, 2'd0, 32'h847C_7CF8);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("areset_busy", 64'(busy_o), 64'd0);
    check("areset_fu_valid", 64'(fu_valid_o), 64'd0);
    check("areset_req_ready", 64'(req_ready_o), 64'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    sb.delete();
    no_rsp_window("reset_no_rsp");

`ifdef CV32E40X_AES_SHARE_MASK_EN
    issue(2'b00, 32'h0, 32'h0000_0053, 2'd0, 32'h0000_00ED);
    m1 = fu_rs3_o[7:0];
    check("share_recombine", 64'(fu_rs2_o[31:24] ^ fu_rs3_o[7:0]), 64'h53);
    wait_rsp();
    issue(2'b00, 32'h0, 32'h0000_0053, 2'd0, 32'h0000_00ED);
    m2 = fu_rs3_o[7:0];
    check("mask_differs", 64'(m1 != m2), 64'd1);
    wait_rsp();
`else
    issue(2'b00, 32'h0, 32'h0000_0053, 2'd0, 32'h0000_00ED);
    m1 = fu_rs3_o[7:0];
    m2 = fu_rs3_o[15:8];
    check("nomask_rs3", 64'(fu_rs3_o), 64'd0);
    check("nomask_rand", 64'(fu_randombits_o), 64'd0);
    check("nomask_rs2", 64'(fu_rs2_o), 64'h5353_0000);
    check("nomask_mask_bytes", 64'({m1, m2}), 64'd0);
    check("op_strobe_encs", 64'({fu_op_encs_o, fu_op_encsm_o, fu_op_decs_o, fu_op_decsm_o}),
          64'b1000);
    wait_rsp();
`endif

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
